// File: rtl/alu_ctrl_seq_if.sv
// Decode request/response bundle between the control unit and alu_ctrl_seq.
// master = issuing control unit, slave = the decoder/sequencer.
interface alu_ctrl_seq_if;
  logic       valid_i;
  logic       ready_o;
  logic       flush_i;
  logic       is_immediate_i;
  logic [1:0] ALU_CO_i;
  logic [6:0] FUNC7_i;
  logic [2:0] FUNC3_i;
  logic [4:0] ALU_OP_o;
  logic       op_valid_o;
  logic       md_start_o;
  logic       busy_o;
  logic       illegal_o;

  modport master (
    output valid_i, flush_i, is_immediate_i, ALU_CO_i, FUNC7_i, FUNC3_i,
    input  ready_o, ALU_OP_o, op_valid_o, md_start_o, busy_o, illegal_o
  );

  modport slave (
    input  valid_i, flush_i, is_immediate_i, ALU_CO_i, FUNC7_i, FUNC3_i,
    output ready_o, ALU_OP_o, op_valid_o, md_start_o, busy_o, illegal_o
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with optional RV32M multi-cycle sequencing.
// Define ALU_CTRL_MULDIV_EN to enable M-op decode and the BUSY latency FSM.
module alu_ctrl_seq #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  alu_ctrl_seq_if.slave bus
);
  localparam logic [4:0] OP_AND  = 5'b00000, OP_OR   = 5'b00001, OP_SUM  = 5'b00010,
                         OP_EQ   = 5'b00011, OP_SLL  = 5'b00100, OP_SRL  = 5'b00101,
                         OP_SRA  = 5'b00111, OP_XOR  = 5'b01000, OP_SUB  = 5'b01010,
                         OP_GE   = 5'b01100, OP_GEU  = 5'b01101, OP_SLT  = 5'b01110,
                         OP_SLTU = 5'b01111;
  localparam logic [6:0] F7_ZERO = 7'b0000000, F7_ALT = 7'b0100000, F7_MD = 7'b0000001;

  if (MUL_LAT < 1 || MUL_LAT > 255 || DIV_LAT < 1 || DIV_LAT > 255 ||
      (2**CNT_W) <= MUL_LAT || (2**CNT_W) <= DIV_LAT) begin : g_bad_param
    $error("alu_ctrl_seq: latency parameters out of range for CNT_W");
  end

  logic [4:0] dec_op;
  logic       dec_ill;
  logic       rdy, accept, md_multi, md_done;
  logic [4:0] op_q;
  logic       vld_q, ill_q;

  always_comb begin
    dec_op  = OP_AND;
    dec_ill = 1'b0;
    case (bus.ALU_CO_i)
      2'b00: dec_op = OP_SUM;
      2'b01: begin
        case (bus.FUNC3_i)
          3'b001:  dec_op = OP_EQ;
          3'b100:  dec_op = OP_GE;
          3'b110:  dec_op = OP_GEU;
          3'b101:  dec_op = OP_SLT;
          3'b111:  dec_op = OP_SLTU;
          default: dec_op = OP_SUB;
        endcase
      end
      2'b10: begin
        if (!bus.is_immediate_i && bus.FUNC7_i == F7_MD) begin
`ifdef ALU_CTRL_MULDIV_EN
          dec_op = {2'b11, bus.FUNC3_i};
`else
          dec_ill = 1'b1;
`endif
        end else begin
          case (bus.FUNC3_i)
            3'b000: begin
              // immediate form has no SUB: funct7 bits are part of the immediate
              if (bus.is_immediate_i || bus.FUNC7_i == F7_ZERO) dec_op = OP_SUM;
              else if (bus.FUNC7_i == F7_ALT)                   dec_op = OP_SUB;
              else                                              dec_ill = 1'b1;
            end
            3'b111: dec_op = OP_AND;
            3'b110: dec_op = OP_OR;
            3'b100: dec_op = OP_XOR;
            3'b010: dec_op = OP_SLT;
            3'b011: dec_op = OP_SLTU;
            3'b001: dec_op = OP_SLL;
            default: begin
              if (bus.FUNC7_i == F7_ZERO)     dec_op = OP_SRL;
              else if (bus.FUNC7_i == F7_ALT) dec_op = OP_SRA;
              else                            dec_ill = 1'b1;
            end
          endcase
        end
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign accept = bus.valid_i & rdy & ~bus.flush_i;

`ifdef ALU_CTRL_MULDIV_EN
  localparam logic [0:0] S_IDLE = 1'b0, S_BUSY = 1'b1;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt, lat_sel;
  logic             is_md, start_q;

  assign is_md    = (bus.ALU_CO_i == 2'b10) & ~bus.is_immediate_i & (bus.FUNC7_i == F7_MD);
  assign lat_sel  = bus.FUNC3_i[2] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
  assign md_multi = is_md & (lat_sel > CNT_W'(1));
  assign md_done  = (state == S_BUSY) & (cnt == '0);

  // counter starts at LAT-2 so the result pulse lands LAT edges after accept
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (bus.flush_i) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else if (state == S_IDLE) begin
        if (accept && md_multi) begin
          state   <= S_BUSY;
          cnt     <= lat_sel - CNT_W'(2);
          start_q <= 1'b1;
        end
      end else if (cnt == '0) begin
        state <= S_IDLE;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign rdy            = (state == S_IDLE);
  assign bus.busy_o     = (state == S_BUSY);
  assign bus.md_start_o = start_q;
`else
  assign md_multi       = 1'b0;
  assign md_done        = 1'b0;
  assign rdy            = 1'b1;
  assign bus.busy_o     = 1'b0;
  assign bus.md_start_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q  <= 5'b00000;
      vld_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      ill_q <= 1'b0;
      if (bus.flush_i) begin
        vld_q <= 1'b0;
      end else if (accept) begin
        op_q <= dec_op;
        if (!md_multi) begin
          vld_q <= 1'b1;
          ill_q <= dec_ill;
        end
      end else if (md_done) begin
        vld_q <= 1'b1;
      end
    end
  end

  assign bus.ready_o    = rdy;
  assign bus.ALU_OP_o   = op_q;
  assign bus.op_valid_o = vld_q;
  assign bus.illegal_o  = ill_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decode table, directed multi-cycle
// sequences and random traffic against a cycle-scheduled reference model.
module tb_alu_ctrl_seq;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 33;
`ifdef ALU_CTRL_MULDIV_EN
  localparam bit MD_EN   = 1'b1;
  localparam int EXP_DIV = DIV_LAT;
  localparam logic [4:0] EXP_DIVU_OP = 5'b11101;
`else
  localparam bit MD_EN   = 1'b0;
  localparam int EXP_DIV = 1;
  localparam logic [4:0] EXP_DIVU_OP = 5'b00000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  alu_ctrl_seq_if bus();
  alu_ctrl_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit fl, input bit imm, input logic [1:0] co,
                       input logic [2:0] f3, input logic [6:0] f7);
    bus.valid_i = v; bus.flush_i = fl; bus.is_immediate_i = imm;
    bus.ALU_CO_i = co; bus.FUNC3_i = f3; bus.FUNC7_i = f7;
  endtask

  // Decode straight from the instruction-set rules.
  function automatic void ref_dec(input logic [1:0] co, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic imm, output logic [4:0] op, output bit ill, output bit md);
    op = 5'd0; ill = 1'b0; md = 1'b0;
    if (co == 2'b00) op = 5'd2;
    else if (co == 2'b01) begin
      if (f3 == 3'b001)      op = 5'd3;
      else if (f3 == 3'b100) op = 5'd12;
      else if (f3 == 3'b110) op = 5'd13;
      else if (f3 == 3'b101) op = 5'd14;
      else if (f3 == 3'b111) op = 5'd15;
      else                   op = 5'd10;
    end else if (co == 2'b10) begin
      if (!imm && f7 == 7'd1) begin
        if (MD_EN) begin op = 5'd24 + 5'(f3); md = 1'b1; end
        else ill = 1'b1;
      end else if (f3 == 3'b000) begin
        if (imm || f7 == 7'd0) op = 5'd2; else if (f7 == 7'h20) op = 5'd10; else ill = 1'b1;
      end else if (f3 == 3'b101) begin
        if (f7 == 7'd0) op = 5'd5; else if (f7 == 7'h20) op = 5'd7; else ill = 1'b1;
      end else if (f3 == 3'b111) op = 5'd0;
      else if (f3 == 3'b110) op = 5'd1;
      else if (f3 == 3'b100) op = 5'd8;
      else if (f3 == 3'b010) op = 5'd14;
      else if (f3 == 3'b011) op = 5'd15;
      else op = 5'd4;
    end else ill = 1'b1;
  endfunction

  // Model: absolute cycle at which a pending multi-cycle result is due.
  int cyc = 0;
  int pend_at = -1;
  logic [4:0] m_op = 5'd0;
  bit m_vld = 0, m_start = 0, m_ill = 0;

  task automatic model_reset;
    pend_at = -1; m_op = 5'd0; m_vld = 0; m_start = 0; m_ill = 0;
  endtask

  task automatic model_step;
    logic [4:0] op; bit ill, md; int lat;
    m_vld = 0; m_start = 0; m_ill = 0;
    if (bus.flush_i) pend_at = -1;
    else if (pend_at >= 0) begin
      if (cyc == pend_at) begin m_vld = 1; pend_at = -1; end
    end else if (bus.valid_i) begin
      ref_dec(bus.ALU_CO_i, bus.FUNC3_i, bus.FUNC7_i, bus.is_immediate_i, op, ill, md);
      m_op = op;
      lat = md ? (bus.FUNC3_i[2] ? DIV_LAT : MUL_LAT) : 1;
      if (lat == 1) begin m_vld = 1; m_ill = ill; end
      else begin m_start = 1; pend_at = cyc + lat - 1; end
    end
    cyc++;
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".op"},       bus.ALU_OP_o,   m_op);
    chk({tag, ".op_valid"}, bus.op_valid_o, m_vld);
    chk({tag, ".md_start"}, bus.md_start_o, m_start);
    chk({tag, ".illegal"},  bus.illegal_o,  m_ill);
    chk({tag, ".busy"},     bus.busy_o,     pend_at >= 0);
    chk({tag, ".ready"},    bus.ready_o,    pend_at < 0);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic cycle(input string tag);
    model_step(); tick(); model_check(tag);
  endtask

  typedef struct {
    logic [1:0] co; logic [2:0] f3; logic [6:0] f7; logic imm;
    logic [4:0] op; logic ill;
  } vec_t;
  vec_t tbl[18];

  initial begin
    int n, pulses;
    tbl[0]  = '{2'b10, 3'b000, 7'h20, 1'b0, 5'b01010, 1'b0};
    tbl[1]  = '{2'b01, 3'b110, 7'h00, 1'b0, 5'b01101, 1'b0};
    tbl[2]  = '{2'b11, 3'b000, 7'h00, 1'b0, 5'b00000, 1'b1};
    tbl[3]  = '{2'b00, 3'b010, 7'h00, 1'b1, 5'b00010, 1'b0};
    tbl[4]  = '{2'b10, 3'b000, 7'h20, 1'b1, 5'b00010, 1'b0};
    tbl[5]  = '{2'b10, 3'b101, 7'h20, 1'b1, 5'b00111, 1'b0};
    tbl[6]  = '{2'b10, 3'b101, 7'h00, 1'b0, 5'b00101, 1'b0};
    tbl[7]  = '{2'b10, 3'b001, 7'h00, 1'b0, 5'b00100, 1'b0};
    tbl[8]  = '{2'b10, 3'b111, 7'h00, 1'b0, 5'b00000, 1'b0};
    tbl[9]  = '{2'b10, 3'b110, 7'h00, 1'b1, 5'b00001, 1'b0};
    tbl[10] = '{2'b10, 3'b100, 7'h00, 1'b0, 5'b01000, 1'b0};
    tbl[11] = '{2'b10, 3'b010, 7'h00, 1'b0, 5'b01110, 1'b0};
    tbl[12] = '{2'b10, 3'b011, 7'h00, 1'b0, 5'b01111, 1'b0};
    tbl[13] = '{2'b01, 3'b001, 7'h00, 1'b0, 5'b00011, 1'b0};
    tbl[14] = '{2'b01, 3'b100, 7'h00, 1'b0, 5'b01100, 1'b0};
    tbl[15] = '{2'b01, 3'b111, 7'h00, 1'b0, 5'b01111, 1'b0};
    tbl[16] = '{2'b10, 3'b000, 7'h02, 1'b0, 5'b00000, 1'b1};
    tbl[17] = '{2'b10, 3'b101, 7'h03, 1'b1, 5'b00000, 1'b1};

    drive(0, 0, 0, 2'b00, 3'b000, 7'h00);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.op", bus.ALU_OP_o, 5'd0);
    chk("rst.op_valid", bus.op_valid_o, 1'b0);
    chk("rst.md_start", bus.md_start_o, 1'b0);
    chk("rst.illegal", bus.illegal_o, 1'b0);
    chk("rst.ready", bus.ready_o, 1'b1);
    chk("rst.busy", bus.busy_o, 1'b0);
    model_reset();
    rst_n = 1'b1;
    cycle("idle");

    // single-cycle decode table
    foreach (tbl[i]) begin
      drive(1, 0, tbl[i].imm, tbl[i].co, tbl[i].f3, tbl[i].f7);
      cycle("tbl");
      chk($sformatf("tbl%0d.op", i), bus.ALU_OP_o, tbl[i].op);
      chk($sformatf("tbl%0d.op_valid", i), bus.op_valid_o, 1'b1);
      chk($sformatf("tbl%0d.illegal", i), bus.illegal_o, tbl[i].ill);
      drive(0, 0, 0, 2'b00, 3'b000, 7'h00);
      cycle("tbl_gap");
      chk($sformatf("tbl%0d.pulse_end", i), bus.op_valid_o, 1'b0);
    end

    // MUL sequencing
    drive(1, 0, 0, 2'b10, 3'b000, 7'h01);
    cycle("mul1");
    drive(0, 0, 0, 2'b00, 3'b000, 7'h00);
`ifdef ALU_CTRL_MULDIV_EN
    chk("mul.c1.md_start", bus.md_start_o, 1'b1);
    chk("mul.c1.ready", bus.ready_o, 1'b0);
    chk("mul.c1.op", bus.ALU_OP_o, 5'b11000);
    chk("mul.c1.op_valid", bus.op_valid_o, 1'b0);
    cycle("mul2");
    chk("mul.c2.md_start", bus.md_start_o, 1'b0);
    chk("mul.c2.ready", bus.ready_o, 1'b0);
    chk("mul.c2.op", bus.ALU_OP_o, 5'b11000);
    cycle("mul3");
    chk("mul.c3.op_valid", bus.op_valid_o, 1'b1);
    chk("mul.c3.op", bus.ALU_OP_o, 5'b11000);
    chk("mul.c3.ready", bus.ready_o, 1'b1);
`else
    chk("mul.c1.op_valid", bus.op_valid_o, 1'b1);
    chk("mul.c1.illegal", bus.illegal_o, 1'b1);
    chk("mul.c1.op", bus.ALU_OP_o, 5'b00000);
    chk("mul.c1.md_start", bus.md_start_o, 1'b0);
`endif
    cycle("mul_end");
    chk("mul.end.op_valid", bus.op_valid_o, 1'b0);

    // DIVU with a second request held behind it
    drive(1, 0, 0, 2'b10, 3'b101, 7'h01);
    cycle("divu");
    n = 1;
    drive(1, 0, 0, 2'b10, 3'b000, 7'h00);
    while (!bus.op_valid_o && n < 40) begin
      cycle("divu_wait");
      n++;
    end
    chk("divu.latency", n, EXP_DIV);
    chk("divu.op", bus.ALU_OP_o, EXP_DIVU_OP);
    chk("divu.ready_at_valid", bus.ready_o, 1'b1);
    cycle("second");
    chk("second.op_valid", bus.op_valid_o, 1'b1);
    chk("second.op", bus.ALU_OP_o, 5'b00010);
    drive(0, 0, 0, 2'b00, 3'b000, 7'h00);
    cycle("second_end");

    // flush during DIV
    drive(1, 0, 0, 2'b10, 3'b100, 7'h01);
    cycle("div_fl");
    drive(0, 0, 0, 2'b00, 3'b000, 7'h00);
    for (int c = 2; c <= 10; c++) cycle("div_fl_wait");
    drive(0, 1, 0, 2'b00, 3'b000, 7'h00);
    cycle("flush");
    chk("flush.busy", bus.busy_o, 1'b0);
    chk("flush.ready", bus.ready_o, 1'b1);
    drive(0, 0, 0, 2'b00, 3'b000, 7'h00);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      cycle("post_flush");
      if (bus.op_valid_o) pulses++;
    end
    chk("flush.no_pulse", pulses, 0);

    // asynchronous reset in the middle of a DIV
    drive(1, 0, 0, 2'b10, 3'b110, 7'h01);
    cycle("div_rst");
    drive(0, 0, 0, 2'b00, 3'b000, 7'h00);
    for (int c = 0; c < 4; c++) cycle("div_rst_wait");
    chk("arst.pre_busy", bus.busy_o, MD_EN);
    #3 rst_n = 1'b0;
    #1;
    chk("arst.op", bus.ALU_OP_o, 5'd0);
    chk("arst.op_valid", bus.op_valid_o, 1'b0);
    chk("arst.md_start", bus.md_start_o, 1'b0);
    chk("arst.illegal", bus.illegal_o, 1'b0);
    chk("arst.busy", bus.busy_o, 1'b0);
    chk("arst.ready", bus.ready_o, 1'b1);
    model_reset();
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      cycle("post_arst");
      if (bus.op_valid_o) pulses++;
    end
    chk("arst.no_pulse", pulses, 0);

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom),
            2'($urandom), 3'($urandom), f7);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Registered, handshaked successor to the combinational ALU control decoder.
- Decodes ALU_CO/FUNC3/FUNC7/is_immediate into a 5-bit ALU operation code.
- Adds RV32M multiply/divide sequencing: a state machine and latency counter hold the op stable and stall the issue stage for a configurable number of cycles.
- Sits between the control unit and the ALU/mul-div unit in the datapath.

Parameters:
- MUL_LAT, 3: cycles from accept to op_valid_o for MUL/MULH/MULHSU/MULHU (FUNC3[2]=0); legal range 1..255.
- DIV_LAT, 33: cycles from accept to op_valid_o for DIV/DIVU/REM/REMU (FUNC3[2]=1); legal range 1..255.
- CNT_W, 8: latency counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  decode request valid.
- ready_o  out  1  block can accept a request this cycle.
- flush_i  in  1  synchronous pipeline flush; aborts any pending op.
- is_immediate_i  in  1  I-type instruction.
- ALU_CO_i  in  2  00 load/store, 01 branch, 10 ALU, 11 invalid.
- FUNC7_i  in  7  instruction funct7.
- FUNC3_i  in  3  instruction funct3.
- ALU_OP_o  out  5  registered ALU operation code.
- op_valid_o  out  1  one-cycle pulse: ALU_OP_o result is ready for consumption.
- md_start_o  out  1  one-cycle pulse: mul/div unit must start.
- busy_o  out  1  multi-cycle op in progress.
- illegal_o  out  1  registered with op_valid_o: the combination was undecodable.

Behaviour:
- Reset (rst_n_i=0, asynchronous): state=IDLE, counter=0, ALU_OP_o=5'b00000, op_valid_o=0, md_start_o=0, illegal_o=0.
- Base encodings are the 4-bit codes zero-extended to 5 bits:
  - AND 00000, OR 00001, SUM 00010, EQUAL 00011, SLL 00100, SRL 00101, SRA 00111.
  - XOR 01000, NOR 01001, SUB 01010, GE 01100, GEU 01101, SLT 01110, SLTU 01111.
- M-op encoding: {2'b11, FUNC3_i}.
- Decode:
  - ALU_CO=00 -> SUM.
  - ALU_CO=01, by FUNC3: 000 SUB, 001 EQUAL, 010 SUB, 011 SUB, 100 GE, 110 GEU, 101 SLT, 111 SLTU.
  - ALU_CO=10: FUNC3 000 -> SUM if immediate or FUNC7=0; SUB if FUNC7=0100000.
  - ALU_CO=10: 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU, 001 SLL.
  - ALU_CO=10: 101 -> SRL if FUNC7=0, SRA if FUNC7=0100000.
  - ALU_CO=10, !is_immediate_i, FUNC7=0000001 -> M op.
  - Any other combination, including ALU_CO=11 -> code 00000 with illegal_o=1.
- Accept occurs when valid_i & ready_o & !flush_i. ready_o = (state==IDLE).
- State IDLE, accepting a single-cycle op, or an M op with LAT=1:
  - Next edge: ALU_OP_o loaded, op_valid_o=1 for one cycle, illegal_o set per decode.
  - Latency is 1.
- State IDLE, accepting an M op with LAT>1:
  - Next edge: ALU_OP_o loaded, md_start_o=1 for one cycle, counter=LAT-2, state=BUSY.
- State BUSY:
  - ready_o=0 and busy_o=1; ALU_OP_o held stable; valid_i ignored.
  - Counter decrements each edge.
  - On the edge where counter==0: op_valid_o=1 and state=IDLE.
  - op_valid_o therefore rises exactly LAT edges after the accept edge.
  - ready_o is 1 during the op_valid_o cycle, so back-to-back issue is allowed.
- flush_i:
  - Any state: next edge state=IDLE, op_valid_o=0, md_start_o=0, busy_o=0, illegal_o=0; ALU_OP_o retains its value.
  - flush_i together with valid_i: flush wins and the request is dropped.
- op_valid_o and md_start_o are never high when no request has been accepted.
- Asynchronous reset mid-BUSY returns to IDLE immediately, with no op_valid_o pulse.

Optional Feature:
- Macro ALU_CTRL_MULDIV_EN.
- Defined: M-op decode and the BUSY sequencing described above.
- Undefined:
  - FUNC7=0000001 on the ALU path decodes as illegal (00000, illegal_o=1), with latency 1.
  - The FSM never leaves IDLE; busy_o and md_start_o are tied 0.
  - MUL_LAT and DIV_LAT are unused.

Test Plan:
- Reset release, then valid_i with ALU_CO=10, FUNC3=000, FUNC7=0100000, imm=0 -> next cycle ALU_OP_o=01010, op_valid_o=1 for one cycle, illegal_o=0.
- ALU_CO=01, FUNC3=110 -> ALU_OP_o=01101. ALU_CO=11 -> ALU_OP_o=00000 with illegal_o=1.
- MUL (FUNC7=0000001, FUNC3=000), MUL_LAT=3:
  - md_start_o pulses at cycle 1 after accept; op_valid_o at cycle 3.
  - ready_o=0 in cycles 1-2; ALU_OP_o=11000 held throughout.
- DIVU (FUNC3=101), DIV_LAT=33, second request held on valid_i:
  - op_valid_o exactly 33 cycles after accept.
  - Second request accepted in the op_valid_o cycle; its result appears one cycle later.
- flush_i asserted at cycle 10 of a DIV:
  - Next cycle busy_o=0, ready_o=1.
  - No op_valid_o pulse is ever produced for the flushed DIV.
- rst_n_i pulsed low mid-BUSY, asynchronously between edges -> all outputs reach reset values before the next edge; no op_valid_o pulse.
